// File: rtl/mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rmw_ctrl
//  Purpose  : Valid/ready request front-end for a word-only single-port SRAM.
//             Provides byte-enable stores by read-modify-write.
//             Optional macro STORE_BYPASS_EN: full-word stores skip the read.
//  Revision : 1.0  initial release
// ============================================================================
module mem_rmw_ctrl #(
    parameter int WORD = 32,
    parameter int ADDR = 16,
    parameter int NBE  = WORD / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [ADDR-1:0] req_addr,
    input  logic [NBE-1:0]  req_be,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [NBE-1:0]  be_q, be_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [ADDR-1:0] mem_a_q, mem_a_d;
    logic            mem_w_q, mem_w_d;
    logic [WORD-1:0] mem_d_q, mem_d_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [WORD-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WORD-1:0] merge;
    logic            bypass_store;

`ifdef STORE_BYPASS_EN
    assign bypass_store = req_we && (req_be == {NBE{1'b1}});
`else
    assign bypass_store = 1'b0;
`endif

    for (genvar i = 0; i < NBE; i++) begin : g_merge
        assign merge[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_Q[8*i +: 8];
    end

    // mem_a_q doubles as the captured request address; it is held until the next accept.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        mem_a_d     = mem_a_q;
        mem_w_d     = 1'b0;
        mem_d_d     = mem_d_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    mem_a_d = req_addr;
                    if (bypass_store) begin
                        mem_d_d     = req_wdata;
                        mem_w_d     = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                rsp_rdata_d = mem_Q;
                if (we_q) begin
                    mem_d_d = merge;
                    mem_w_d = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Asynchronous clear guarantees mem_W drops before the next edge when reset hits mid-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            mem_a_q     <= '0;
            mem_w_q     <= 1'b0;
            mem_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            mem_a_q     <= mem_a_d;
            mem_w_q     <= mem_w_d;
            mem_d_q     <= mem_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_A     = mem_a_q;
    assign mem_W     = mem_w_q;
    assign mem_D     = mem_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rmw_ctrl
//  Purpose  : Directed self-checking bench for mem_rmw_ctrl with a behavioural SRAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_rmw_ctrl;

`ifdef STORE_BYPASS_EN
    localparam int         C_FULL_LAT = 2;
    localparam logic       C_FULL_W1  = 1'b1;
`else
    localparam int         C_FULL_LAT = 4;
    localparam logic       C_FULL_W1  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [15:0] mem_A;
    logic        mem_W;
    logic [31:0] mem_D, mem_Q;

    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:65535];

    int npass = 0, ntotal = 0, nfail = 0;
    int wcnt = 0, rspcnt = 0;

    mem_rmw_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_A     (mem_A),
        .mem_W     (mem_W),
        .mem_D     (mem_D),
        .mem_Q     (mem_Q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_W) mem[mem_A] <= mem_D;
        else       mem_Q <= mem[mem_A];
    end

    always @(posedge clk) begin
        if (mem_W)     wcnt++;
        if (rsp_valid) rspcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request from IDLE and returns the cycle index of rsp_valid (1 = cycle after accept).
    task automatic do_req(input logic we, input logic [15:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic first_w, output logic ready_seen);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        lat        = 0;
        rd         = 'x;
        first_w    = mem_W;
        ready_seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                break;
            end
            if (req_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, k, r0, w0;
        logic [31:0] rd, rd1;
        logic        fw, rs;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_be = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_A", 32'(mem_A), 32'h0);
        chk("rst_mem_W", 32'(mem_W), 32'h0);
        chk("rst_mem_D", mem_D, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk); rst = 1'b0;

        // 1: plain load
        preload(16'h0010, 32'hDEADBEEF);
        do_req(1'b0, 16'h0010, 4'h0, 32'h0, lat, rd, fw, rs);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_ready_busy", 32'(rs), 32'h0);

        // 2: partial store then reload
        preload(16'h0020, 32'h11223344);
        w0 = wcnt;
        do_req(1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD, lat, rd, fw, rs);
        chk("t2_latency", 32'(lat), 32'd4);
        chk("t2_old_word", rd, 32'h11223344);
        chk("t2_mem", mem[16'h0020], 32'h11BB33DD);
        chk("t2_w_cycles", 32'(wcnt - w0), 32'd1);
        do_req(1'b0, 16'h0020, 4'h0, 32'h0, lat, rd, fw, rs);
        chk("t2_reload", rd, 32'h11BB33DD);

        // 3: full-word store
        preload(16'h0030, 32'h0);
        do_req(1'b1, 16'h0030, 4'hF, 32'hCAFEF00D, lat, rd, fw, rs);
        chk("t3_latency", 32'(lat), 32'(C_FULL_LAT));
        chk("t3_first_w", 32'(fw), 32'(C_FULL_W1));
        chk("t3_rdata", rd, 32'h0);
        chk("t3_mem", mem[16'h0030], 32'hCAFEF00D);
        do_req(1'b0, 16'h0030, 4'h0, 32'h0, lat, rd, fw, rs);
        chk("t3_reload", rd, 32'hCAFEF00D);

        // 4: back-to-back loads with req_valid held
        r0 = rspcnt;
        rd1 = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        @(posedge clk); #1;
        req_addr = 16'h0020;
        k = 1;
        while (!req_ready && k < 12) begin
            if (rsp_valid) rd1 = rsp_rdata;
            @(posedge clk); #1;
            k++;
        end
        chk("t4_reaccept_cycle", 32'(k), 32'd4);
        chk("t4_rdata1", rd1, 32'hDEADBEEF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd = 'x;
        for (int j = 1; j <= 12; j++) begin
            if (rsp_valid) begin
                rd = rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t4_rdata2", rd, 32'h11BB33DD);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_rsp_pulses", 32'(rspcnt - r0), 32'd2);

        // 5: reset during WRITE of a partial store
        preload(16'h0020, 32'h11223344);
        r0 = rspcnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020;
        req_be = 4'b0101; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("t5_in_write", 32'(mem_W), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_w_async_drop", 32'(mem_W), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("t5_ready_after", 32'(req_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_mem_kept", mem[16'h0020], 32'h11223344);
        chk("t5_no_rsp", 32'(rspcnt - r0), 32'd0);

        // 6: top address
        preload(16'h0000, 32'h01020304);
        preload(16'hFFFF, 32'h0);
        do_req(1'b1, 16'hFFFF, 4'b1000, 32'h5A000000, lat, rd, fw, rs);
        chk("t6_latency", 32'(lat), 32'd4);
        chk("t6_old_word", rd, 32'h0);
        chk("t6_mem_top", mem[16'hFFFF], 32'h5A000000);
        chk("t6_mem_zero", mem[16'h0000], 32'h01020304);

        // be==0 store writes the old word back
        preload(16'h0040, 32'h12345678);
        w0 = wcnt;
        do_req(1'b1, 16'h0040, 4'h0, 32'hFFFFFFFF, lat, rd, fw, rs);
        chk("be0_latency", 32'(lat), 32'd4);
        chk("be0_old_word", rd, 32'h12345678);
        chk("be0_mem", mem[16'h0040], 32'h12345678);
        chk("be0_w_cycles", 32'(wcnt - w0), 32'd1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
